// File: rtl/isr_sched_pkg.sv
// Shared types and widths for the round-robin integer square-root scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package isr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int ISR_OPERAND_W = 64;
    localparam int ISR_RESULT_W  = 32;
    localparam int ISR_LATENCY   = 32;

endpackage

// File: rtl/isr_scheduler_if.sv
// Request/response bundle between client datapaths and the sqrt scheduler.
// Latency: none (wires only).
// Backpressure: valid/ready on both the request and the response side.
interface isr_scheduler_if
    import isr_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ*ISR_OPERAND_W-1:0] req_value;
    logic [NUM_REQ-1:0]               req_ready;
    logic                             resp_valid;
    logic                             resp_ready;
    logic [ID_W-1:0]                  resp_id;
    logic [ISR_RESULT_W-1:0]          resp_result;
    logic                             busy;

    modport master (
        output req_valid, req_value, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result, busy
    );

    modport slave (
        input  req_valid, req_value, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result, busy
    );

endinterface

// File: rtl/ISR.sv
// Iterative integer square root: floor(sqrt(value)), two operand bits per cycle.
// Latency: done rises 32 edges after reset is released; result then holds.
// Backpressure: none; value must stay stable while the unit iterates.
module ISR
    import isr_sched_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ISR_OPERAND_W-1:0] value,
    output logic [ISR_RESULT_W-1:0]  result,
    output logic                     done
);
    logic [ISR_RESULT_W-1:0] root_q, root_d;
    logic [35:0]             rem_q, rem_d;
    logic [4:0]              cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic [35:0]             rem_sh;
    logic [35:0]             trial;
    logic [4:0]              pair_idx;

    // One digit-by-digit step per cycle, most significant operand pair first.
    always_comb begin
        root_d   = root_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        pair_idx = 5'd31 - cnt_q;
        rem_sh   = (rem_q << 2) | {34'b0, value[{pair_idx, 1'b0} +: 2]};
        trial    = {2'b00, root_q, 2'b01};
        if (!done_q) begin
            if (rem_sh >= trial) begin
                rem_d  = rem_sh - trial;
                root_d = {root_q[ISR_RESULT_W-2:0], 1'b1};
            end else begin
                rem_d  = rem_sh;
                root_d = {root_q[ISR_RESULT_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                done_d = 1'b1;
            end
        end
    end

    // Iteration state; reset restarts the computation from the current value.
    always_ff @(posedge clock) begin
        if (reset) begin
            root_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            root_q <= root_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign result = root_q;
    assign done   = done_q;

endmodule

// File: rtl/isr_scheduler.sv
// Round-robin arbiter sharing one ISR unit among NUM_REQ requesters.
// Latency: 35 cycles from request acceptance to resp_valid; 36-cycle best issue interval.
// Backpressure: req_ready only in IDLE; the response is held until resp_ready.
module isr_scheduler
    import isr_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic          clock,
    input  logic          reset,
    isr_scheduler_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    state_t                   state_q, state_d;
    logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]          id_q, id_d;
    logic [ISR_OPERAND_W-1:0] op_q, op_d;
    logic [ISR_RESULT_W-1:0]  res_q, res_d;
    logic [NUM_REQ-1:0]       grant;
    logic [ID_W:0]            pick;
    logic                     isr_rst;
    logic [ISR_RESULT_W-1:0]  isr_result;
    logic                     isr_done;

    // First valid requester at or after ptr, wrapping at NUM_REQ; MSB flags a hit.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (vld[idx]) begin
                res = {1'b1, idx[ID_W-1:0]};
            end
        end
        return res;
    endfunction

    // Next-state, grant and capture logic for the four-state controller.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        op_d     = op_q;
        res_d    = res_q;
        grant    = '0;
        pick     = rr_pick(bus.req_valid, rr_ptr_q);
        case (state_q)
            IDLE: begin
                if (pick[ID_W]) begin
                    grant[pick[ID_W-1:0]] = 1'b1;
                    op_d    = bus.req_value[ISR_OPERAND_W*int'(pick[ID_W-1:0]) +: ISR_OPERAND_W];
                    id_d    = pick[ID_W-1:0];
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (isr_done) begin
                    res_d   = isr_result;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state and captured operand/result; reset abandons any in-flight op.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            op_q     <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            op_q     <= op_d;
            res_q    <= res_d;
        end
    end

    // The stale done from a previous operation is cleared by this restart pulse.
    assign isr_rst = reset | (state_q == START);

    ISR u_isr (
        .clock  (clock),
        .reset  (isr_rst),
        .value  (op_q),
        .result (isr_result),
        .done   (isr_done)
    );

    assign bus.req_ready   = grant;
    assign bus.resp_valid  = (state_q == RESP);
    assign bus.resp_id     = id_q;
    assign bus.resp_result = res_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: doc/isr_scheduler.md
# isr_scheduler

Round-robin scheduler that shares one iterative integer square-root unit (`ISR`) among `NUM_REQ` requesters. Each requester submits a 64-bit operand over a valid/ready handshake. The block holds the operand stable, starts the unit, waits for `done`, and returns the 32-bit root tagged with the requester ID over a valid/ready response channel. It sits between client datapaths and the single `ISR` instance, and it is the only agent that drives that instance.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16)
- `ID_W`, `$clog2(NUM_REQ)`, derived; not overridden
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `req_valid` in `NUM_REQ`: per-requester request valid
- `req_value` in `NUM_REQ*64`: flattened operands; requester i at `[64*i +: 64]`
- `req_ready` out `NUM_REQ`: one-hot grant; high only in IDLE
- `resp_valid` out 1: result available
- `resp_ready` in 1: consumer accepts result
- `resp_id` out `ID_W`: requester that issued the operand
- `resp_result` out 32: floor(sqrt(operand))
- `busy` out 1: state != IDLE

## Operation
- States: IDLE, START, WAIT, RESP.
- **IDLE**
  - Grant g is the first i with `req_valid[i]`, searching from `rr_ptr` upward with wrap.
  - `req_ready[g]=1`; all other bits are 0.
  - On handshake: latch `req_value[g]` into `op_q` and g into `id_q`, then go to START.
  - With no `req_valid`, stay in IDLE.
- **START** (exactly 1 cycle): assert the `ISR` reset input, then go to WAIT.
- **WAIT**
  - Hold `op_q` on the `ISR` `value` input.
  - When `ISR` `done`=1: capture `ISR` `result` into `res_q` and go to RESP.
- **RESP**
  - Drive `resp_valid=1`, `resp_id=id_q`, `resp_result=res_q`.
  - Hold all three stable until `resp_ready`.
  - On handshake: `rr_ptr <= (id_q+1) mod NUM_REQ`, then go to IDLE.
- `ISR` reset input = `reset | (state==START)`.
  - `done` is stale from the previous operation until the START edge; it is sampled only in WAIT.
- Arithmetic: `NUM_REQ` non-power-of-two wraps at `NUM_REQ`, not at `2**ID_W`.
- `req_value` changes after acceptance are ignored; only `op_q` feeds `ISR`.
- A requester may drop `req_valid` without a handshake; this has no side effect.
- No new request is accepted in the RESP-handshake cycle; acceptance occurs earliest in the following IDLE cycle.
- Reset mid-operation, in any state:
  - next state IDLE, `rr_ptr=0`; the in-flight operation is discarded with no response.
  - The `ISR` is restarted via its reset input; its result is ignored.

## Timing
- Reset values: `req_ready=0`, `resp_valid=0`, `resp_id=0`, `resp_result=0`, `busy=0`, `rr_ptr=0`, `op_q=0`, `id_q=0`, `res_q=0`.
- Request accepted at the end of cycle A.
- START in cycle A+1.
- `ISR` computes over 32 edges; `done` is visible in cycle A+34.
- `resp_valid` goes high in cycle A+35, so accept-to-response latency is 35 cycles.
- With `resp_ready` tied high, IDLE is reached in A+36; best-case issue interval is 36 cycles.
- `req_ready` is combinational from `state`, `rr_ptr` and `req_valid`. All other outputs are registered.
- `busy` is high from A+1 through the RESP handshake cycle inclusive.

## Structure
- Package `isr_sched_pkg`:
  - `state_t` enum {IDLE, START, WAIT, RESP}
  - `ISR_OPERAND_W=64`, `ISR_RESULT_W=32`, `ISR_LATENCY=32`
- One sub-module instance: the existing `ISR` unit, instantiated unmodified. Its `value` port is tied to `op_q`.
- Round-robin pick is a function or always_comb block in the same file; it is not a separate module.

## Test plan
- **Single requests:**
  - req0 value 144 accepted in cycle A.
  - Required response: `resp_valid` in A+35, `resp_id=0`, `resp_result=12`, `busy` high A+1..A+35.
- **Boundary operands:**
  - 0 → 0
  - 15 → 3
  - 16 → 4
  - 64'hFFFF_FFFF_FFFF_FFFF → 32'hFFFF_FFFF
  - 64'hFFFF_FFFE_0000_0001 → 32'hFFFF_FFFF
- **Fairness:**
  - All four `req_valid` held high from reset release with values 1, 4, 9, 16.
  - Required response order: IDs 0, 1, 2, 3, then 0 again, with results 1, 2, 3, 4.
  - Each grant is one-hot.
- **Backpressure:**
  - `resp_ready` held low for 10 cycles in RESP.
  - Required: `resp_valid`, `resp_id` and `resp_result` are stable; `req_ready=0` throughout; a new operand is accepted only after the handshake.
- **Operand stability:**
  - `req_value[1]` changes from 100 to 49 one cycle after acceptance.
  - Required: `resp_result=10`.
- **Reset in WAIT:**
  - `reset` pulsed at A+20 during a 144 operation.
  - Required: no response emitted and all outputs at reset values.
  - A subsequent request 81 from req2 returns 9 with `resp_id=2`, 35 cycles after its acceptance.
